fifo_rd_ctrl: RTL

//  Read-side controller of the dual-clock pointer FIFO, the counterpart of the write-side logic.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/sync_w2r.sv | 22 ++
 rtl/fifo_rd_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and Gray-code helpers for both pointer domains
package fifo_pkg;
  localparam int ADDRSIZE = 3;
  localparam int DSIZE = 8;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_w2r.sv
// sync_w2r: two-flop synchroniser bringing the Gray write pointer into rclk
module sync_w2r #(
  parameter int W = 4
) (
  input  logic         rclk,
  input  logic         rrst_n,
  input  logic [W-1:0] wptr,
  output logic [W-1:0] rq2_wptr
);
  logic [W-1:0] rq1_q, rq2_q;
  // Only one Gray bit changes per write, so each flop sees at most one bit in flight
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= wptr;
      rq2_q <= rq1_q;
    end
  end
  assign rq2_wptr = rq2_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, empty flag and valid/ready output stage with a 1-entry skid
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE,
  parameter int DSIZE    = fifo_pkg::DSIZE
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DSIZE-1:0]    rdata_in,
  output logic [DSIZE-1:0]    rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel
);
  localparam int PW = ADDRSIZE + 1;
  logic [PW-1:0]    rq2_wptr;
  logic [PW-1:0]    rbin_q, rbin_d, rptr_q, rgray_d, rlevel_q, rlevel_d;
  logic             rempty_q, rempty_d, pend_q;
  logic             rd_valid_q, rd_valid_d, skid_valid_q, skid_valid_d;
  logic             pop, skid_load;
  logic [1:0]       occ;
  logic [DSIZE-1:0] rd_data_q, rd_data_d, skid_q, skid_d;

  sync_w2r #(.W(PW)) u_sync (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .wptr     (wptr),
    .rq2_wptr (rq2_wptr)
  );

  // Pointer/empty next state: a read is issued only when the output stage has room for its data
  always_comb begin
    occ      = 2'(pend_q) + 2'(rd_valid_q) + 2'(skid_valid_q);
    pop      = rd_valid_q & rd_ready;
    ren      = !rempty_q & ((occ < 2'd2) | ((occ == 2'd2) & pop));
    rbin_d   = rbin_q + PW'(ren);
    rgray_d  = PW'(bin2gray(32'(rbin_d)));
    rempty_d = rgray_d == rq2_wptr;
    rlevel_d = PW'(gray2bin(32'(rq2_wptr))) - rbin_d;
  end

  // Output stage: RAM data lands in rd_data when it is free or draining, otherwise parks in the skid
  always_comb begin
    skid_load    = pend_q & rd_valid_q & (!pop | skid_valid_q);
    rd_valid_d   = pop ? (skid_valid_q | pend_q) : (rd_valid_q | pend_q);
    rd_data_d    = (pop & skid_valid_q) ? skid_q :
                   (pend_q & (!rd_valid_q | pop)) ? rdata_in : rd_data_q;
    skid_valid_d = skid_load ? 1'b1 : pop ? 1'b0 : skid_valid_q;
    skid_d       = skid_load ? rdata_in : skid_q;
  end

  // State registers; reset discards in-flight RAM data and the skid contents
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      rlevel_q     <= '0;
      pend_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      rd_data_q    <= '0;
      skid_q       <= '0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rgray_d;
      rempty_q     <= rempty_d;
      rlevel_q     <= rlevel_d;
      pend_q       <= ren;
      rd_valid_q   <= rd_valid_d;
      skid_valid_q <= skid_valid_d;
      rd_data_q    <= rd_data_d;
      skid_q       <= skid_d;
    end
  end

  assign rptr     = rptr_q;
  assign raddr    = rbin_q[ADDRSIZE-1:0];
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rempty   = rempty_q;
  assign rlevel   = rlevel_q;
endmodule
